// File: rtl/hal_sdpram_clr_pkg.sv
// Shared HAL definitions for the clearable simple-dual-port RAM:
// state encoding, lane-count helper and byte-lane merge.
package hal_sdpram_clr_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sdpramState_e;

    // Widest word the merge helper handles; callers cast to and from this width.
    localparam int unsigned MAX_DW = 1024;

    function automatic int unsigned laneCount(input int unsigned dw, input int unsigned bw);
        return dw / bw;
    endfunction

    // Lanes whose enable bit is set take newW; all other lanes keep oldW.
    function automatic logic [MAX_DW-1:0] mergeLanes(
        input logic [MAX_DW-1:0] oldW,
        input logic [MAX_DW-1:0] newW,
        input logic [MAX_DW-1:0] laneEn,
        input int unsigned       bw
    );
        logic [MAX_DW-1:0] res;
        res = oldW;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (laneEn[i / bw]) begin
                res[i] = newW[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hal_sdpram_array.sv
// Bare behavioural storage: 2^AW x DW words, per-lane write, registered read.
// Contents are deliberately unreset so synthesis maps this onto block RAM.
module hal_sdpram_array
    import hal_sdpram_clr_pkg::*;
#(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 5,
    parameter int unsigned BW = 8
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [DW/BW-1:0]   mask_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic               re_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [DW-1:0]      rdata_o
);

    localparam int unsigned NL = laneCount(DW, BW);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Read-before-write: a same-address read returns the pre-write word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < NL; l++) begin
                if (mask_i[l]) begin
                    mem_q[waddr_i][l*BW +: BW] <= wdata_i[l*BW +: BW];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hal_sdpram_clr.sv
// Simple-dual-port RAM with post-reset zero sweep and optional write-to-read bypass.
// Owns the sweep FSM, the bypass register and QA hold/zero logic around the storage.
module hal_sdpram_clr
    import hal_sdpram_clr_pkg::*;
#(
    parameter int unsigned DW         = 128,
    parameter int unsigned AW         = 5,
    parameter int unsigned BW         = 8,
    parameter int unsigned INIT_CLEAR = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               BUSY,
    input  logic               CENA,
    input  logic [AW-1:0]      AA,
    output logic [DW-1:0]      QA,
    input  logic               CENB,
    input  logic [DW/BW-1:0]   WENB,
    input  logic [AW-1:0]      AB,
    input  logic [DW-1:0]      DB
);

    localparam int unsigned  NL        = laneCount(DW, BW);
    localparam logic [AW:0]  SWEEP_END = {1'b1, {AW{1'b0}}};

    if (DW % BW != 0) begin : gBadWidth
        $error("hal_sdpram_clr: DW must be a multiple of BW");
    end

    sdpramState_e   state_q, state_d;
    logic [AW:0]    cnt_q, cnt_d;

    logic           arrWe;
    logic           arrRe;
    logic [NL-1:0]  arrMask;
    logic [AW-1:0]  arrWaddr;
    logic [DW-1:0]  arrWdata;
    logic [DW-1:0]  arrQ;

    logic           rdValid_q;
    logic           collide_q;
    logic [DW-1:0]  byData_q;
    logic [NL-1:0]  byMask_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arrWe    = 1'b0;
        arrRe    = 1'b0;
        arrMask  = '0;
        arrWaddr = AB;
        arrWdata = DB;
        if (!RST) begin
            unique case (state_q)
                ST_CLEAR: begin
                    // The counter runs one past the last word so the exit test never wraps.
                    if (INIT_CLEAR != 0) begin
                        if (cnt_q == SWEEP_END) begin
                            state_d = ST_RUN;
                        end else begin
                            arrWe    = 1'b1;
                            arrMask  = '1;
                            arrWaddr = cnt_q[AW-1:0];
                            arrWdata = '0;
                            cnt_d    = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    arrWe   = !CENB;
                    arrMask = ~WENB;
                    arrRe   = !CENA;
                end
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            rdValid_q <= 1'b0;
            collide_q <= 1'b0;
            byData_q  <= '0;
            byMask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Capture write data and lanes at read time; the merge happens after the register.
            if (arrRe) begin
                rdValid_q <= 1'b1;
                collide_q <= (BYPASS != 0) && !CENB && (AA == AB);
                byData_q  <= DB;
                byMask_q  <= ~WENB;
            end
        end
    end

    hal_sdpram_array #(
        .DW (DW),
        .AW (AW),
        .BW (BW)
    ) uArray (
        .clk_i   (CLK),
        .we_i    (arrWe),
        .mask_i  (arrMask),
        .waddr_i (arrWaddr),
        .wdata_i (arrWdata),
        .re_i    (arrRe),
        .raddr_i (AA),
        .rdata_o (arrQ)
    );

    assign BUSY = (state_q == ST_CLEAR);

    always_comb begin
        QA = '0;
        if (rdValid_q) begin
            if (collide_q) begin
                QA = DW'(mergeLanes(MAX_DW'(arrQ), MAX_DW'(byData_q), MAX_DW'(byMask_q), BW));
            end else begin
                QA = arrQ;
            end
        end
    end

endmodule

// File: doc/hal_sdpram_clr.md
# hal_sdpram_clr

Parametrised simple-dual-port RAM for the HAL layer: one read port (A), one byte-maskable write port (B), one-cycle read latency, an optional post-reset zero sweep and optional same-address write-to-read bypass. It generalises the fixed-geometry cache tag/data wrappers so dcache, icache and the USB buffers share one macro. Because block RAM contents are not reset, it also supplies the cleared-tag guarantee that the caches rely on.

## Interface
- DW, 128: data width in bits; must be a multiple of BW.
- AW, 5: address width; depth = 2^AW words.
- BW, 8: byte-lane width; lanes NL = DW/BW. Set BW = DW for a single-lane RAM.
- INIT_CLEAR, 1: 1 = write zero to every word after reset; 0 = no sweep.
- BYPASS, 1: 1 = a read colliding with a same-cycle write returns the new data; 0 = returns the old data.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- BUSY  out  1  high while reset or the sweep is in progress; ports are ignored while high.
- CENA  in  1  read enable, active-low.
- AA  in  AW  read address.
- QA  out  DW  read data.
- CENB  in  1  write enable, active-low.
- WENB  in  NL  per-lane write enable, active-low.
- AB  in  AW  write address.
- DB  in  DW  write data.

## Operation
FSM states: CLEAR, RUN.

- **RST high.** State = CLEAR, sweep counter = 0, BUSY = 1, QA = 0. Memory is not written.
- **CLEAR with INIT_CLEAR = 1.**
  - Each cycle writes zero to word[counter] on all lanes, then increments the counter.
  - After the write to 2^AW-1, the next state is RUN and BUSY drops.
  - CENA, CENB, WENB, AA, AB and DB are ignored. QA holds 0.
- **CLEAR with INIT_CLEAR = 0.** Go to RUN on the first cycle with RST low.
- **Reset mid-sweep.** The sweep restarts at 0 when RST is released. Partially cleared contents carry no guarantee.
- **RUN, write.** When CENB = 0, each lane i with WENB[i] = 0 writes DB lane i to word[AB]. A write with all WENB bits high is a no-op.
- **RUN, read.** When CENA = 0, QA shows word[AA] on the next edge. When CENA = 1, QA holds its last value and does not go to X.
- **RUN, collision** (CENA = 0, CENB = 0, AA == AB):
  - BYPASS = 1: QA shows the old word with the written lanes replaced by DB.
  - BYPASS = 0: QA shows the old word entirely.
  - Memory is always updated.
- **Width rules.** DW % BW != 0 is an elaboration error. Counter width is AW+1 so the terminal test does not wrap.

## Timing
- Read latency is 1 cycle: QA is valid on the edge after CENA = 0 is sampled.
- Write is committed at the sampling edge. A read of the same address issued on the following cycle returns the new data regardless of BYPASS.
- Sweep, INIT_CLEAR = 1:
  - The first cycle with RST low writes address 0.
  - BUSY is low starting 2^AW+1 edges after RST falls (2^AW writes plus the transition edge).
- Sweep, INIT_CLEAR = 0: BUSY is low one edge after RST falls.
- Reset values: BUSY = 1, QA = 0, state = CLEAR, counter = 0.
- Bypass path: the collision flag and merged lanes are registered in the read cycle. QA is selected by a mux after that register. There is no combinational path from DB to QA.

## Structure
- Shared HAL package holds:
  - the state encoding (CLEAR/RUN);
  - the helper function for lane count, DW/BW;
  - the merge function for byte-enable lanes, which replaces masked lanes of an old word with new data.
- One natural sub-module: hal_sdpram_array.
  - Holds the bare behavioural storage (2^AW x DW, per-lane write, registered read) so synthesis infers BSRAM.
  - The top owns the FSM, the sweep counter, the bypass register and the QA hold logic.

## Test plan
(Parameters DW = 16, AW = 4, BW = 8, unless stated otherwise.)

1. **Sweep.**
   - Stimulus: preload the array with 0xFFFF, pulse RST for 2 cycles with INIT_CLEAR = 1, then read all 16 addresses.
   - Required: BUSY stays high for exactly 17 edges after RST falls; every read returns 0x0000; no port access is honoured while BUSY is high.
2. **Byte write.**
   - Stimulus: write 0xABCD to address 3 with WENB = 2'b00, then write 0x1200 with WENB = 2'b01, then read address 3.
   - Required: QA = 0x12CD one cycle after the read.
3. **Collision.**
   - Stimulus: address 5 holds 0x1111; in one cycle read address 5 and write 0x2222 with WENB = 2'b10.
   - Required: QA = 0x1122 with BYPASS = 1, QA = 0x1111 with BYPASS = 0; the next read of address 5 returns 0x1122 in both cases.
4. **Hold.**
   - Stimulus: read address 2 holding 0x5A5A, then keep CENA high for 5 cycles while writing address 2.
   - Required: QA stays 0x5A5A.
5. **Reset mid-sweep.**
   - Stimulus: assert RST when the counter = 9, release it.
   - Required: the sweep restarts at address 0; BUSY is high for 17 more edges; all 16 words read 0x0000.
6. **INIT_CLEAR = 0.**
   - Stimulus: release RST.
   - Required: BUSY is low after 1 edge; a write of 0x00FF to address 0 followed by a read returns 0x00FF.
